// File: rtl/bcd_scroller.sv
// rtl/bcd_scroller.sv - sequential double-dabble binary-to-BCD converter with a scrollable 4-digit window
module bcd_scroller (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] binary_i,
   input  logic        scroll_l_i,
   input  logic        scroll_r_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic [1:0]  pos_o,
   output logic [15:0] window_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] bin_q, bin_d;
   logic [19:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic [23:0] digits_q, digits_d;
   logic [1:0]  pos_q, pos_d;
   logic        valid_q, valid_d;

   logic [19:0] adj;
   logic [35:0] shifted;
   logic [15:0] magnitude;

   assign magnitude = binary_i[15] ? (~binary_i + 16'd1) : binary_i;

   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      digits_d = digits_q;
      pos_d    = pos_q;
      valid_d  = valid_q;

      // One double-dabble iteration: correct nibbles >= 5, then shift {bcd, bin}.
      adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj[18:0], bin_q, 1'b0};

      case (state_q)
         ST_CONV: begin
            bcd_d = shifted[35:16];
            bin_d = shifted[15:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               digits_d = {(neg_q ? 4'hA : 4'hF), shifted[35:16]};
               valid_d  = 1'b1;
               state_d  = ST_DONE;
            end
         end
         default: begin
            if (start_i) begin
               bin_d   = magnitude;
               bcd_d   = 20'd0;
               cnt_d   = 4'd0;
               neg_d   = binary_i[15];
               pos_d   = 2'd0;
               valid_d = 1'b0;
               state_d = ST_CONV;
            end else if (state_q == ST_DONE) begin
               if (scroll_l_i && !scroll_r_i && pos_q != 2'd2) begin
                  pos_d = pos_q + 2'd1;
               end else if (scroll_r_i && !scroll_l_i && pos_q != 2'd0) begin
                  pos_d = pos_q - 2'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         bin_q    <= 16'd0;
         bcd_q    <= 20'd0;
         cnt_q    <= 4'd0;
         neg_q    <= 1'b0;
         digits_q <= {4'hF, 20'd0};
         pos_q    <= 2'd0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         digits_q <= digits_d;
         pos_q    <= pos_d;
         valid_q  <= valid_d;
      end
   end

   assign busy_o  = (state_q == ST_CONV);
   assign valid_o = valid_q;
   assign pos_o   = pos_q;

   always_comb begin
      case (pos_q)
         2'd1:    window_o = digits_q[19:4];
         2'd2:    window_o = digits_q[23:8];
         default: window_o = digits_q[15:0];
      endcase
   end

endmodule

// File: tb/tb_bcd_scroller.sv
// tb/tb_bcd_scroller.sv - randomized self-checking bench for bcd_scroller against a digit-array reference model
module tb_bcd_scroller;

   logic        clk = 1'b0;
   logic        rst, start, scroll_l, scroll_r;
   logic [15:0] binary;
   logic        busy, valid;
   logic [1:0]  pos;
   logic [15:0] window;

   always #5 clk = ~clk;

   bcd_scroller dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .binary_i   (binary),
      .scroll_l_i (scroll_l),
      .scroll_r_i (scroll_r),
      .busy_o     (busy),
      .valid_o    (valid),
      .pos_o      (pos),
      .window_o   (window)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: displayed digits as an array, index 5 = sign glyph .. 0 = units.
   int         m_left;
   bit         m_valid;
   int         m_pos;
   logic [3:0] m_disp [6];
   logic [3:0] m_pend [6];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_left  = 0;
      m_valid = 0;
      m_pos   = 0;
      m_disp[5] = 4'hF;
      for (int i = 0; i < 5; i++) m_disp[i] = 4'h0;
   endtask

   task automatic make_digits(input logic [15:0] b);
      int mag;
      int p;
      mag = b[15] ? 65536 - int'(b) : int'(b);
      p = 1;
      for (int i = 0; i < 5; i++) begin
         m_pend[i] = 4'((mag / p) % 10);
         p = p * 10;
      end
      m_pend[5] = b[15] ? 4'hA : 4'hF;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            for (int i = 0; i < 6; i++) m_disp[i] = m_pend[i];
            m_valid = 1;
         end
      end else if (start) begin
         make_digits(binary);
         m_left  = 16;
         m_valid = 0;
         m_pos   = 0;
      end else if (m_valid) begin
         if (scroll_l && !scroll_r && m_pos < 2) m_pos++;
         else if (scroll_r && !scroll_l && m_pos > 0) m_pos--;
      end
   endtask

   function automatic logic [15:0] exp_window();
      return {m_disp[m_pos+3], m_disp[m_pos+2], m_disp[m_pos+1], m_disp[m_pos]};
   endfunction

   task automatic step(input logic s, input logic [15:0] b, input logic l, input logic r, input logic rs);
      start = s; binary = b; scroll_l = l; scroll_r = r; rst = rs;
      @(posedge clk);
      model_edge();
      #1;
      start = 0; scroll_l = 0; scroll_r = 0; rst = 0;
      check_eq("busy",   32'(busy),   32'(m_left > 0));
      check_eq("valid",  32'(valid),  32'(m_valid));
      check_eq("pos",    32'(pos),    32'(m_pos));
      check_eq("window", 32'(window), 32'(exp_window()));
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 16'h0, 0, 0, 0);
   endtask

   int bc;
   logic [15:0] rb;

   initial begin
      rst = 1; start = 0; scroll_l = 0; scroll_r = 0; binary = 16'h0;
      model_reset();
      step(0, 16'h0, 0, 0, 1);
      check_eq("reset_window", 32'(window), 32'h0000);
      check_eq("reset_valid",  32'(valid),  32'h0);

      // zero: busy length and first scroll
      step(1, 16'h0000, 0, 0, 0);
      bc = int'(busy);
      repeat (16) begin
         step(0, 16'h0, 0, 0, 0);
         bc += int'(busy);
      end
      check_eq("busy_len", 32'(bc), 32'd16);
      check_eq("zero_valid", 32'(valid), 32'h1);
      check_eq("zero_win", 32'(window), 32'h0000);
      step(0, 16'h0, 1, 0, 0);
      step(0, 16'h0, 1, 0, 0);
      check_eq("zero_pos2", 32'(window), 32'hF000);

      // 12345 scroll walk
      step(1, 16'h3039, 0, 0, 0);
      idle(16);
      check_eq("w12345_p0", 32'(window), 32'h2345);
      step(0, 16'h0, 1, 0, 0);
      check_eq("w12345_p1", 32'(window), 32'h1234);
      step(0, 16'h0, 1, 0, 0);
      check_eq("w12345_p2", 32'(window), 32'hF123);
      step(0, 16'h0, 1, 0, 0);
      check_eq("sat_hi", 32'(pos), 32'd2);
      repeat (3) step(0, 16'h0, 0, 1, 0);
      check_eq("sat_lo", 32'(pos), 32'd0);
      step(0, 16'h0, 1, 0, 0);
      step(0, 16'h0, 1, 1, 0);
      check_eq("both_scroll", 32'(pos), 32'd1);

      // start beats scroll; second start mid-conversion ignored
      step(1, 16'h00FF, 1, 0, 0);
      check_eq("start_wins", 32'(pos), 32'd0);
      idle(4);
      step(1, 16'h1234, 0, 0, 0);
      idle(11);
      check_eq("ignore_start", 32'(window), 32'h0255);
      check_eq("ignore_valid", 32'(valid), 32'h1);

      // negative values
      step(1, 16'hC000, 0, 0, 0);
      idle(16);
      check_eq("neg16384_p0", 32'(window), 32'h6384);
      step(0, 16'h0, 1, 0, 0);
      step(0, 16'h0, 1, 0, 0);
      check_eq("neg16384_p2", 32'(window), 32'hA163);
      step(1, 16'h8000, 0, 0, 0);
      idle(16);
      check_eq("neg32768_p0", 32'(window), 32'h2768);
      step(0, 16'h0, 1, 0, 0);
      step(0, 16'h0, 1, 0, 0);
      check_eq("neg32768_p2", 32'(window), 32'hA327);

      // reset in the middle of a conversion
      step(1, 16'h3039, 0, 0, 0);
      idle(7);
      step(0, 16'h0, 0, 0, 1);
      check_eq("midrst_busy",  32'(busy),   32'h0);
      check_eq("midrst_valid", 32'(valid),  32'h0);
      check_eq("midrst_win",   32'(window), 32'h0000);
      step(0, 16'h0, 1, 0, 0);
      check_eq("idle_scroll", 32'(pos), 32'd0);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 5))
            0:       rb = 16'h8000;
            1:       rb = 16'h7FFF;
            2:       rb = 16'hFFFF;
            default: rb = 16'($urandom);
         endcase
         step($urandom_range(0, 7) == 0, rb,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 99) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
